// File: rtl/instr_sequencer.sv
// Program sequencer: fetches 16-bit instructions over a req/valid handshake, gates the
// control unit with run until done, and handles branches, HALT, single-step and done-timeout.
module instr_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int RESET_PC     = 0,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       instruction,
    output logic              run,
    input  logic              done,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       retired,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    localparam int                TW    = $clog2(DONE_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] PC0   = ADDR_W'(RESET_PC);
    localparam logic [TW-1:0]     TLAST = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_PAUSE,
        S_HALT,
        S_ERROR
    } state_t;

    state_t            state;
    logic [TW-1:0]     tcount;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;
    logic              take_branch;

    // The held instruction decides where the PC goes when the control unit retires it.
    always_comb begin
        target      = ADDR_W'(instruction[12:5]);
        take_branch = (instruction[1:0] == 2'b10) && alu_zero;
        next_pc     = take_branch ? target : pc + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= PC0;
            mem_addr    <= PC0;
            mem_req     <= 1'b0;
            instruction <= '0;
            run         <= 1'b0;
            retired     <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            error       <= 1'b0;
            tcount      <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state    <= S_FETCH;
                        pc       <= PC0;
                        mem_addr <= PC0;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (mem_valid) begin
                        instruction <= mem_rdata;
                        mem_req     <= 1'b0;
                        if (mem_rdata[1:0] == 2'b11) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            state  <= S_EXEC;
                            run    <= 1'b1;
                            tcount <= '0;
                        end
                    end
                end
                S_EXEC: begin
                    // A done arriving on the last allowed cycle still retires normally.
                    if (done) begin
                        pc      <= next_pc;
                        retired <= retired + 16'd1;
                        run     <= 1'b0;
                        if (step_mode) begin
                            state <= S_PAUSE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_FETCH;
                            mem_req  <= 1'b1;
                            mem_addr <= next_pc;
                        end
                    end else if (tcount == TLAST) begin
                        state <= S_ERROR;
                        run   <= 1'b0;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (step || !step_mode) begin
                        state    <= S_FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        busy     <= 1'b1;
                    end
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a behavioural memory/control-unit driver plus an
// instruction-level reference model (pc, retire count) checked per retired instruction.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_valid = 1'b0;
    logic [15:0] instruction;
    logic        run;
    logic        done = 1'b0;
    logic        alu_zero = 1'b0;
    logic [7:0]  pc;
    logic [15:0] retired;
    logic        busy;
    logic        halted;
    logic        error;

    logic [15:0] imem [256];
    int          total = 0;
    int          bad = 0;

    instr_sequencer #(.ADDR_W(8), .RESET_PC(0), .DONE_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .instruction(instruction), .run(run), .done(done), .alu_zero(alu_zero),
        .pc(pc), .retired(retired), .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Architectural next-PC rule: J-type with zero flag branches to bits 12:5.
    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic [15:0] ins, input bit z);
        int kind = int'(ins) % 4;
        int tgt = (int'(ins) / 32) % 256;
        int seq = (int'(cur) + 1) % 256;
        return (kind == 2 && z) ? 8'(tgt) : 8'(seq);
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] w = 16'($urandom);
        w[1:0] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    task automatic fill_imem();
        for (int i = 0; i < 256; i++) imem[i] = rand_instr();
    endtask

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; step = 1'b0; done = 1'b0;
        mem_valid = 1'b0; step_mode = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    // Memory side: waits for a request, answers after lat cycles with one valid beat.
    task automatic do_fetch(input int lat, output logic [7:0] addr, output bit ok);
        int waited = 0;
        ok = 1'b1;
        addr = 8'h0;
        while (mem_req !== 1'b1) begin
            if (waited == 50) begin
                ok = 1'b0;
                return;
            end
            waited++;
            @(negedge clk);
        end
        addr = mem_addr;
        for (int i = 1; i < lat; i++) begin
            mem_rdata = 16'($urandom);
            @(negedge clk);
        end
        mem_rdata = imem[addr];
        mem_valid = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0;
        mem_rdata = 16'($urandom);
    endtask

    // Control-unit side: pulses done on the dly-th cycle of run, counts run-high cycles.
    task automatic do_exec(input int dly, input bit z, output int cnt, output logic [15:0] ins, output bit ok);
        cnt = 0;
        ok = 1'b0;
        ins = 16'h0;
        for (int k = 0; k < 200; k++) begin
            done = 1'b0;
            alu_zero = !z;
            if (run === 1'b1) begin
                cnt++;
                if (cnt == 1) ins = instruction;
                if (cnt == dly) begin
                    done = 1'b1;
                    alu_zero = z;
                end
            end else if (cnt > 0) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        done = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (pc !== 8'h00) begin bad++; $display("[TB] FAIL reset_pc: got %0h want 0", pc); end
        total++; if (instruction !== 16'h0) begin bad++; $display("[TB] FAIL reset_instr: got %0h want 0", instruction); end
        total++; if (run !== 1'b0) begin bad++; $display("[TB] FAIL reset_run: got %0b want 0", run); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %0b want 0", mem_req); end
        total++; if (retired !== 16'h0) begin bad++; $display("[TB] FAIL reset_retired: got %0h want 0", retired); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted: got %0b want 0", halted); end
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error: got %0b want 0", error); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        done = 1'b1; mem_valid = 1'b1; step = 1'b1;
        repeat (3) @(negedge clk);
        done = 1'b0; mem_valid = 1'b0; step = 1'b0;
        total++; if (mem_req !== 1'b0 || run !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL idle_ignore: got req=%0b run=%0b busy=%0b want 0/0/0", mem_req, run, busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] a; logic [15:0] ins; int cnt; bit ok;
        apply_reset();
        fill_imem();
        imem[0] = 16'h2400;
        pulse_start();
        do_fetch(2, a, ok);
        total++; if (!ok || a !== 8'h00) begin bad++; $display("[TB] FAIL basic_fetch: got ok=%0b addr=%0h want 1/0", ok, a); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL basic_req_drop: got %0b want 0", mem_req); end
        do_exec(5, 1'b0, cnt, ins, ok);
        total++; if (!ok || cnt != 5) begin bad++; $display("[TB] FAIL basic_run_len: got %0d want 5", cnt); end
        total++; if (ins !== 16'h2400) begin bad++; $display("[TB] FAIL basic_instr: got %0h want 2400", ins); end
        total++; if (pc !== 8'h01) begin bad++; $display("[TB] FAIL basic_pc: got %0h want 1", pc); end
        total++; if (retired !== 16'h1) begin bad++; $display("[TB] FAIL basic_retired: got %0h want 1", retired); end
        total++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin
            bad++; $display("[TB] FAIL basic_next_fetch: got req=%0b addr=%0h want 1/1", mem_req, mem_addr);
        end
        total++; if (busy !== 1'b1 || run !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy: got busy=%0b run=%0b want 1/0", busy, run); end
    endtask

    task automatic test_random();
        logic [7:0] a; logic [7:0] m_pc; logic [15:0] m_ret; logic [15:0] ins; logic [15:0] w;
        int cnt; int lat; int dly; bit z; bit ok;
        apply_reset();
        fill_imem();
        pulse_start();
        m_pc = 8'h00;
        m_ret = 16'h0;
        for (int n = 0; n < 25; n++) begin
            lat = int'($urandom_range(1, 4));
            dly = int'($urandom_range(1, 6));
            z = 1'($urandom);
            w = imem[m_pc];
            do_fetch(lat, a, ok);
            total++; if (!ok || a !== m_pc) begin bad++; $display("[TB] FAIL rand_addr: got %0h want %0h", a, m_pc); end
            do_exec(dly, z, cnt, ins, ok);
            total++; if (!ok || cnt != dly) begin bad++; $display("[TB] FAIL rand_run_len: got %0d want %0d", cnt, dly); end
            total++; if (ins !== w) begin bad++; $display("[TB] FAIL rand_instr: got %0h want %0h", ins, w); end
            m_pc = ref_next(m_pc, w, z);
            m_ret = m_ret + 16'd1;
            total++; if (pc !== m_pc) begin bad++; $display("[TB] FAIL rand_pc: got %0h want %0h", pc, m_pc); end
            total++; if (retired !== m_ret) begin bad++; $display("[TB] FAIL rand_retired: got %0h want %0h", retired, m_ret); end
            if (!ok) break;
        end
    endtask

    task automatic test_branch();
        logic [7:0] a; logic [7:0] want; logic [15:0] ins; int cnt; bit ok; bit z;
        for (int r = 0; r < 2; r++) begin
            z = (r == 0);
            apply_reset();
            fill_imem();
            for (int i = 0; i < 3; i++) imem[i] = 16'($urandom) & 16'hFFFC;
            imem[3] = 16'h0402;
            pulse_start();
            for (int i = 0; i < 4; i++) begin
                do_fetch(1, a, ok);
                do_exec(2, (i == 3) ? z : 1'b1, cnt, ins, ok);
            end
            want = z ? 8'h20 : 8'h04;
            total++; if (pc !== want || mem_addr !== want) begin
                bad++; $display("[TB] FAIL branch_z%0b: got pc=%0h addr=%0h want %0h", z, pc, mem_addr, want);
            end
        end
    endtask

    task automatic test_halt();
        logic [7:0] a; logic [15:0] ins; int cnt; bit ok; bit saw_run;
        apply_reset();
        fill_imem();
        imem[0] = 16'h2400;
        imem[1] = 16'h0003;
        pulse_start();
        do_fetch(1, a, ok);
        do_exec(3, 1'b0, cnt, ins, ok);
        do_fetch(3, a, ok);
        total++; if (!ok || a !== 8'h01) begin bad++; $display("[TB] FAIL halt_fetch: got %0h want 1", a); end
        total++; if (halted !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("[TB] FAIL halt_state: got halted=%0b busy=%0b req=%0b want 1/0/0", halted, busy, mem_req);
        end
        saw_run = (run === 1'b1);
        done = 1'b1; step = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (run === 1'b1) saw_run = 1'b1;
        end
        done = 1'b0; step = 1'b0;
        total++; if (saw_run) begin bad++; $display("[TB] FAIL halt_run: got 1 want 0"); end
        total++; if (pc !== 8'h01 || halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_pc: got pc=%0h halted=%0b want 1/1", pc, halted); end
        pulse_start();
        total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || halted !== 1'b0) begin
            bad++; $display("[TB] FAIL halt_restart: got req=%0b addr=%0h halted=%0b want 1/0/0", mem_req, mem_addr, halted);
        end
        total++; if (retired !== 16'h1) begin bad++; $display("[TB] FAIL halt_keep_retired: got %0h want 1", retired); end
    endtask

    task automatic test_step();
        logic [7:0] a; logic [7:0] m_pc; logic [15:0] ins; logic [15:0] w; int cnt; bit ok; bit saw_req;
        apply_reset();
        fill_imem();
        step_mode = 1'b1;
        pulse_start();
        w = imem[0];
        do_fetch(2, a, ok);
        step = 1'b1;
        do_exec(3, 1'b1, cnt, ins, ok);
        step = 1'b0;
        m_pc = ref_next(8'h00, w, 1'b1);
        total++; if (!ok || cnt != 3) begin bad++; $display("[TB] FAIL step_stray: got run_len=%0d want 3", cnt); end
        total++; if (pc !== m_pc) begin bad++; $display("[TB] FAIL step_pc: got %0h want %0h", pc, m_pc); end
        saw_req = (mem_req === 1'b1);
        done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            done = 1'b0;
            if (mem_req === 1'b1) saw_req = 1'b1;
        end
        total++; if (saw_req || busy !== 1'b0) begin bad++; $display("[TB] FAIL step_pause: got req_seen=%0b busy=%0b want 0/0", saw_req, busy); end
        total++; if (retired !== 16'h1) begin bad++; $display("[TB] FAIL step_retired: got %0h want 1", retired); end
        pulse_step();
        total++; if (mem_req !== 1'b1 || mem_addr !== m_pc) begin
            bad++; $display("[TB] FAIL step_resume: got req=%0b addr=%0h want 1/%0h", mem_req, mem_addr, m_pc);
        end
        w = imem[m_pc];
        do_fetch(1, a, ok);
        do_exec(1, 1'b0, cnt, ins, ok);
        m_pc = ref_next(m_pc, w, 1'b0);
        total++; if (mem_req !== 1'b0 || pc !== m_pc) begin bad++; $display("[TB] FAIL step_second: got req=%0b pc=%0h want 0/%0h", mem_req, pc, m_pc); end
        step_mode = 1'b0;
        @(negedge clk);
        total++; if (mem_req !== 1'b1 || mem_addr !== m_pc) begin
            bad++; $display("[TB] FAIL step_mode_drop: got req=%0b addr=%0h want 1/%0h", mem_req, mem_addr, m_pc);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] a; logic [15:0] ins; int cnt; bit ok;
        apply_reset();
        fill_imem();
        imem[0] = 16'h2400;
        pulse_start();
        do_fetch(1, a, ok);
        do_exec(1000, 1'b0, cnt, ins, ok);
        total++; if (!ok || cnt != 64) begin bad++; $display("[TB] FAIL timeout_len: got %0d want 64", cnt); end
        total++; if (error !== 1'b1 || run !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL timeout_flag: got err=%0b run=%0b busy=%0b want 1/0/0", error, run, busy);
        end
        pulse_start();
        done = 1'b1; mem_valid = 1'b1;
        repeat (4) @(negedge clk);
        done = 1'b0; mem_valid = 1'b0;
        total++; if (error !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("[TB] FAIL timeout_sticky: got err=%0b req=%0b want 1/0", error, mem_req); end
        apply_reset();
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL timeout_clear: got %0b want 0", error); end
        pulse_start();
        do_fetch(1, a, ok);
        do_exec(2, 1'b0, cnt, ins, ok);
        total++; if (mem_req !== 1'b1 || retired !== 16'h1) begin
            bad++; $display("[TB] FAIL midfetch_pre: got req=%0b retired=%0h want 1/1", mem_req, retired);
        end
        reset = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 16'h1234;
        @(negedge clk);
        reset = 1'b0;
        mem_valid = 1'b0;
        total++; if (pc !== 8'h00 || instruction !== 16'h0 || run !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("[TB] FAIL midfetch_reset: got pc=%0h ins=%0h run=%0b req=%0b want 0/0/0/0", pc, instruction, run, mem_req);
        end
        total++; if (retired !== 16'h0 || halted !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL midfetch_flags: got ret=%0h halt=%0b err=%0b busy=%0b want 0/0/0/0", retired, halted, error, busy);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] a; logic [15:0] ins; int cnt; bit ok;
        apply_reset();
        fill_imem();
        imem[0] = 16'h1FE2;
        imem[255] = 16'h2400;
        step_mode = 1'b1;
        pulse_start();
        do_fetch(1, a, ok);
        do_exec(2, 1'b1, cnt, ins, ok);
        total++; if (pc !== 8'hFF) begin bad++; $display("[TB] FAIL wrap_branch: got %0h want ff", pc); end
        force dut.retired = 16'hFFFF;
        @(negedge clk);
        release dut.retired;
        @(negedge clk);
        total++; if (retired !== 16'hFFFF) begin bad++; $display("[TB] FAIL wrap_preload: got %0h want ffff", retired); end
        pulse_step();
        do_fetch(2, a, ok);
        total++; if (!ok || a !== 8'hFF) begin bad++; $display("[TB] FAIL wrap_fetch: got %0h want ff", a); end
        do_exec(1, 1'b0, cnt, ins, ok);
        total++; if (pc !== 8'h00) begin bad++; $display("[TB] FAIL wrap_pc: got %0h want 0", pc); end
        total++; if (retired !== 16'h0) begin bad++; $display("[TB] FAIL wrap_retired: got %0h want 0", retired); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_branch();
        test_halt();
        test_step();
        test_timeout();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
